// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Buffered UART receiver: 8N1 framing (8E1 when UART_RX_PARITY_EN is defined),
// 16x oversampling with a 3-sample majority vote at ticks 7/8/9 of every bit.
// Received bytes land in a first-word-fall-through FIFO drained through a
// valid/ready read port. Sticky framing-error and overrun flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Adds an even-parity bit after data bit 7 and the sticky parity_error port.
//
// Ports
//   clk          fabric clock, all logic on posedge
//   rst          synchronous active-high reset
//   uartrx       asynchronous serial input, idles high
//   rd_data      byte at FIFO head (0 while the FIFO is empty)
//   rd_valid     FIFO not empty
//   rd_ready     consumer accepts; pop when rd_valid && rd_ready
//   fifo_count   bytes currently stored
//   frame_error  sticky, stop bit sampled low
//   overrun      sticky, a complete byte was dropped on a full FIFO
//   parity_error sticky, parity mismatch (UART_RX_PARITY_EN only)
//   err_clear    clears all sticky flags
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD * 16)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uartrx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_error,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_error,
`endif
  input  logic                          err_clear
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Control state
  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, line_prev_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         tick_idx_q, tick_idx_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               push_q, push_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fe_q, fe_d, ov_q, ov_d;

  // Datapath state (no reset)
  logic [1:0]         samp_q, samp_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         push_data_q, push_data_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

`ifdef UART_RX_PARITY_EN
  logic               pe_q, pe_d;
  logic               par_bad_q, par_bad_d;
`endif

  logic line, tick, at_t9, at_t15, maj;
  logic fe_set, pe_set, ov_set;
  logic do_pop, full, wr_en;

  assign line   = sync2_q;
  assign tick   = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign at_t9  = tick && (tick_idx_q == 4'd9);
  assign at_t15 = tick && (tick_idx_q == 4'd15);
  // Samples from ticks 7 and 8 are held; tick 9 uses the live line value.
  assign maj    = majority3(samp_q[0], samp_q[1], line);

  // Receive FSM, oversample timing and shift register
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tick_idx_d  = tick_idx_q;
    bit_idx_d   = bit_idx_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    fe_set      = 1'b0;
    pe_set      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif

    if (state_q == S_IDLE || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (tick) begin
      tick_idx_d = tick_idx_q + 4'd1;
      if (tick_idx_q == 4'd7) samp_d[0] = line;
      if (tick_idx_q == 4'd8) samp_d[1] = line;
    end

    case (state_q)
      S_IDLE: begin
        tick_idx_d = 4'd0;
        if (line_prev_q && !line) state_d = S_START;
      end
      S_START: begin
        // A start bit that reads high at mid-bit was only a glitch.
        if (at_t9 && maj) begin
          state_d = S_IDLE;
        end else if (at_t15) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (at_t9) shift_d = {maj, shift_q[7:1]};
        if (at_t15) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        // Even parity: data bits plus parity bit must XOR to zero.
        if (at_t9) par_bad_d = maj ^ (^shift_q);
        if (at_t15) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Decided mid stop bit so the next start edge is not missed.
        if (at_t9) begin
          if (maj) begin
            push_d      = 1'b1;
            push_data_d = shift_q;
`ifdef UART_RX_PARITY_EN
            pe_set      = par_bad_q;
`endif
            state_d     = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, count and sticky flags
  always_comb begin
    do_pop   = rd_valid && rd_ready;
    full     = (count_q == FULL_CNT);
    // When full, a simultaneous pop frees the slot being written.
    wr_en    = push_q && (!full || do_pop);
    ov_set   = push_q && full && !do_pop;
    wr_ptr_d = wr_en  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(do_pop);

    fe_d = fe_set ? 1'b1 : (err_clear ? 1'b0 : fe_q);
    ov_d = ov_set ? 1'b1 : (err_clear ? 1'b0 : ov_q);
`ifdef UART_RX_PARITY_EN
    pe_d = pe_set ? 1'b1 : (err_clear ? 1'b0 : pe_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      div_q       <= '0;
      tick_idx_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fe_q        <= 1'b0;
      ov_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= uartrx;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      div_q       <= div_d;
      tick_idx_q  <= tick_idx_d;
      bit_idx_q   <= bit_idx_d;
      push_q      <= push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fe_q        <= fe_d;
      ov_q        <= ov_d;
`ifdef UART_RX_PARITY_EN
      pe_q        <= pe_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    samp_q      <= samp_d;
    shift_q     <= shift_d;
    push_data_q <= push_data_d;
`ifdef UART_RX_PARITY_EN
    par_bad_q   <= par_bad_d;
`endif
    if (wr_en) mem_q[wr_ptr_q] <= push_data_q;
  end

  // Storage is not reset; gating on rd_valid keeps rd_data at 0 when empty.
  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign frame_error = fe_q;
  assign overrun     = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. Runs the receiver at 16 oversample
// ticks of 4 clocks each so whole frames stay short. A queue-based model
// tracks which bytes should be stored, which sticky flags should be set,
// and the expected push latency derived from the bit timing.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 15625;
  localparam int T        = CLK_FREQ / (BAUD * 16);   // 4 clocks per tick
  localparam int BIT      = 16 * T;                    // clocks per bit
  localparam int DEPTH    = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN   = 1'b1;
`else
  localparam bit PAR_EN   = 1'b0;
`endif
  localparam int FB       = PAR_EN ? 11 : 10;          // bits per frame
  // Stop-bit mid-sample tick counted from the start edge, plus two
  // synchronizer flops, edge detect, stop decision and the FIFO write.
  localparam int LAT_LO   = ((FB - 1) * 16 + 10) * T;
  localparam int LAT_HI   = LAT_LO + 8;
  localparam int LAT_NOM  = LAT_LO + 4;

  logic       clk = 1'b0;
  logic       rst, uartrx, rd_ready, err_clear;
  logic [7:0] rd_data;
  logic       rd_valid, frame_error, overrun;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH),
    .TICK_DIV  (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uartrx      (uartrx),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .fifo_count  (fifo_count),
    .frame_error (frame_error),
    .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .err_clear   (err_clear)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_q[$];
  logic       fe_exp, ov_exp, pe_exp;
  int         lat_meas;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    logic [10:0] bits;
    bits = PAR_EN ? {stop_bit, par_bit, b, 1'b0} : {1'b1, stop_bit, b, 1'b0};
    for (int i = 0; i < FB; i++) begin
      uartrx = bits[i];
      cyc(BIT);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else ov_exp = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
    model_push(b);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_fe"}, frame_error, fe_exp);
    chk({tag, "_ov"}, overrun, ov_exp);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_pe"}, parity_error, pe_exp);
`endif
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, fifo_count, model_q.size());
    while (model_q.size() > 0) begin
      cyc($urandom_range(0, 3));
      @(negedge clk);
      chk({tag, "_valid"}, rd_valid, 1);
      chk({tag, "_data"}, rd_data, model_q[0]);
      rd_ready = 1'b1;
      @(posedge clk);
      #1;
      rd_ready = 1'b0;
      void'(model_q.pop_front());
    end
    @(negedge clk);
    chk({tag, "_empty_valid"}, rd_valid, 0);
    chk({tag, "_empty_count"}, fifo_count, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit got;
    int d_use;

    uartrx = 1'b1; rst = 1'b1; rd_ready = 1'b0; err_clear = 1'b0;
    fe_exp = 1'b0; ov_exp = 1'b0; pe_exp = 1'b0;
    cyc(3);
    rst = 1'b0;

    // Reset state
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_count", fifo_count, 0);
    chk_flags("rst");

    // Reading an empty FIFO does nothing
    rd_ready = 1'b1;
    cyc(5);
    chk("empty_pop_count", fifo_count, 0);
    chk("empty_pop_valid", rd_valid, 0);
    rd_ready = 1'b0;
    cyc(BIT);

    // Single byte with latency measurement
    lat_meas = 0;
    got = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        while (!got && lat_meas < FB * BIT + 2 * BIT) begin
          @(posedge clk);
          #2;
          lat_meas++;
          if (rd_valid) got = 1'b1;
        end
      end
    join
    @(posedge clk);
    #1;
    model_push(8'hA5);
    chk("lat_seen", got, 1);
    chk("lat_window", (lat_meas >= LAT_LO && lat_meas <= LAT_HI), 1);
    chk("single_count", fifo_count, 1);
    drain("single");

    // Back-to-back frames
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h55);
    send_byte(8'h80);
    chk("b2b_count", fifo_count, 4);
    chk_flags("b2b");
    drain("b2b");

    // Overrun: 17th byte dropped
    for (int i = 1; i <= 17; i++) send_byte(8'(i));
    cyc(2);
    chk("ovr_count", fifo_count, DEPTH);
    chk("ovr_head", rd_data, 8'h01);
    chk_flags("ovr");
    drain("ovr");
    pulse_clear();
    ov_exp = 1'b0;
    chk_flags("ovr_clr");

    // Full FIFO with a pop in the push cycle of byte 17
    d_use = (lat_meas >= LAT_LO && lat_meas <= LAT_HI) ? lat_meas : LAT_NOM;
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    fork
      send_frame(8'h11, 1'b1, ^8'h11);
      begin
        repeat (d_use - 1) @(posedge clk);
        #1 rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_q.push_back(8'h11);
    cyc(2);
    chk("ovpop_count", fifo_count, DEPTH);
    chk_flags("ovpop");
    drain("ovpop");

    // Framing error, break, then a good byte
    send_frame(8'h3C, 1'b0, ^8'h3C);
    fe_exp = 1'b1;
    cyc(20 * BIT);
    uartrx = 1'b1;
    cyc(2 * BIT);
    send_byte(8'h42);
    chk_flags("frm");
    drain("frm");
    pulse_clear();
    fe_exp = 1'b0;
    chk_flags("frm_clr");

    // 1.5-tick glitch is rejected
    uartrx = 1'b0;
    cyc(T + T / 2);
    uartrx = 1'b1;
    cyc(12 * BIT);
    chk("glitch_count", fifo_count, 0);
    chk_flags("glitch");

    // Reset in the middle of a frame
    send_byte(8'h5A);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    fe_exp = 1'b1;
    uartrx = 1'b1;
    cyc(BIT);
    chk("prerst_count", fifo_count, 1);
    chk_flags("prerst");
    b = 8'h99;
    uartrx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      uartrx = b[i];
      cyc(BIT);
    end
    uartrx = b[4];
    cyc(BIT / 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    uartrx = 1'b1;
    model_q.delete();
    fe_exp = 1'b0; ov_exp = 1'b0; pe_exp = 1'b0;
    cyc(12 * BIT);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", rd_valid, 0);
    chk_flags("midrst");
    send_byte(8'h27);
    drain("postrst");

`ifdef UART_RX_PARITY_EN
    // Parity mismatch still stores the byte
    send_frame(8'h07, 1'b1, 1'b0);
    model_push(8'h07);
    pe_exp = 1'b1;
    chk_flags("par_bad");
    drain("par_bad");
    pulse_clear();
    pe_exp = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    model_push(8'h07);
    chk_flags("par_ok");
    drain("par_ok");
`endif

    // Randomized traffic with occasional bad stop bits
    for (int r = 0; r < 4; r++) begin
      int k;
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          send_frame(b, 1'b0, ^b);
          fe_exp = 1'b1;
          uartrx = 1'b1;
          cyc(BIT);
        end else begin
          send_byte(b);
        end
        cyc($urandom_range(0, 40));
      end
      chk_flags("rnd");
      drain("rnd");
      pulse_clear();
      fe_exp = 1'b0; ov_exp = 1'b0; pe_exp = 1'b0;
      chk_flags("rnd_clr");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
